// File: rtl/sr_pulse_pkg.sv
// rtl/sr_pulse_pkg.sv - shared states and constants for the SR latch pulse debouncer
package sr_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PULSE_S,
        PULSE_R,
        GAP
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_PULSE_CYCLES    = 2;
    localparam int DEF_CNT_W           = 8;

    // Released level of every active-low signal in this block
    localparam logic INACTIVE = 1'b1;

endpackage

// File: rtl/sr_pulse_debouncer_debounce_cell.sv
// rtl/sr_pulse_debouncer_debounce_cell.sv - two-flop synchronizer, debounce counter and press strobe
module debounce_cell
    import sr_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic fall
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             deb;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= INACTIVE;
            s2   <= INACTIVE;
            deb  <= INACTIVE;
            cnt  <= '0;
            fall <= 1'b0;
        end else begin
            s1   <= raw_n;
            s2   <= s1;
            fall <= 1'b0;
            // Any cycle that agrees with the debounced level restarts the count
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                deb  <= s2;
                cnt  <= '0;
                fall <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_pulse_debouncer.sv
// rtl/sr_pulse_debouncer.sv - debounced presses to non-overlapping Sbar/Rbar pulses for a NAND latch
module sr_pulse_debouncer
    import sr_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic set_n_raw,
    input  logic clr_n_raw,
    output logic Sbar,
    output logic Rbar,
    output logic busy,
    output logic conflict
);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

    logic             set_fall;
    logic             clr_fall;
    logic             req_s;
    logic             req_r;
    state_t           state;
    state_t           state_nx;
    logic             sbar_nx;
    logic             rbar_nx;
    logic             conflict_nx;
    logic             pend_s;
    logic             pend_r;
    logic             pend_s_nx;
    logic             pend_r_nx;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] pcnt_nx;

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_set_cell (
        .clk   (clk),
        .reset (reset),
        .raw_n (set_n_raw),
        .fall  (set_fall)
    );

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clr_cell (
        .clk   (clk),
        .reset (reset),
        .raw_n (clr_n_raw),
        .fall  (clr_fall)
    );

    assign req_s = set_fall | pend_s;
    assign req_r = clr_fall | pend_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            Sbar     <= INACTIVE;
            Rbar     <= INACTIVE;
            conflict <= 1'b0;
            pend_s   <= 1'b0;
            pend_r   <= 1'b0;
            pcnt     <= '0;
        end else begin
            state    <= state_nx;
            Sbar     <= sbar_nx;
            Rbar     <= rbar_nx;
            conflict <= conflict_nx;
            pend_s   <= pend_s_nx;
            pend_r   <= pend_r_nx;
            pcnt     <= pcnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        sbar_nx     = Sbar;
        rbar_nx     = Rbar;
        conflict_nx = 1'b0;
        pend_s_nx   = pend_s;
        pend_r_nx   = pend_r;
        pcnt_nx     = pcnt;
        case (state)
            IDLE: begin
                // Both sides asking at once would drive the latch into its forbidden state
                if (req_s && req_r) begin
                    conflict_nx = 1'b1;
                    pend_s_nx   = 1'b0;
                    pend_r_nx   = 1'b0;
                end else if (req_s) begin
                    state_nx  = PULSE_S;
                    sbar_nx   = ~INACTIVE;
                    pcnt_nx   = PULSE_LAST;
                    pend_s_nx = 1'b0;
                end else if (req_r) begin
                    state_nx  = PULSE_R;
                    rbar_nx   = ~INACTIVE;
                    pcnt_nx   = PULSE_LAST;
                    pend_r_nx = 1'b0;
                end
            end
            PULSE_S, PULSE_R: begin
                pend_s_nx = pend_s | set_fall;
                pend_r_nx = pend_r | clr_fall;
                if (pcnt == '0) begin
                    sbar_nx  = INACTIVE;
                    rbar_nx  = INACTIVE;
                    state_nx = GAP;
                end else begin
                    pcnt_nx = pcnt - 1'b1;
                end
            end
            GAP: begin
                pend_s_nx = pend_s | set_fall;
                pend_r_nx = pend_r | clr_fall;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sr_pulse_debouncer.sv
// tb/tb_sr_pulse_debouncer.sv - scoreboard bench for sr_pulse_debouncer
module tb_sr_pulse_debouncer;

    localparam int D    = 4;
    localparam int P    = 2;
    localparam int NMAX = 4096;

    localparam int K_SF = 0;
    localparam int K_SR = 1;
    localparam int K_RF = 2;
    localparam int K_RR = 3;
    localparam int K_CF = 4;

    typedef struct {
        int t;
        int k;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    logic set_n_raw;
    logic clr_n_raw;
    logic Sbar;
    logic Rbar;
    logic busy;
    logic conflict;

    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;
    ev_t  q[$];

    logic raw_s [NMAX];
    logic raw_r [NMAX];
    logic busy_exp [NMAX];
    int   last_rst;
    logic deb_s, deb_r, fprev_s, fprev_r, pend_s_m, pend_r_m;
    int   next_free;
    int   p_start;
    int   p_kind;
    int   cur_t;
    logic prev_s = 1'b1;
    logic prev_r = 1'b1;

    sr_pulse_debouncer #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .set_n_raw (set_n_raw),
        .clr_n_raw (clr_n_raw),
        .Sbar      (Sbar),
        .Rbar      (Rbar),
        .busy      (busy),
        .conflict  (conflict)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic string kname(input int k);
        case (k)
            K_SF:    return "Sbar_fall";
            K_SR:    return "Sbar_rise";
            K_RF:    return "Rbar_fall";
            K_RR:    return "Rbar_rise";
            default: return "conflict";
        endcase
    endfunction

    function automatic logic raw_eff(input int which, input int k);
        if (k < 0 || k <= last_rst) return 1'b1;
        return (which != 0) ? raw_r[k] : raw_s[k];
    endfunction

    // Debounced level flips at edge t when the last D synchronized samples all disagree with it
    function automatic logic flips(input int which, input int t, input logic deb);
        for (int j = 0; j < D; j++)
            if (raw_eff(which, t - 2 - j) == deb) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void push_ev(input int t, input int k);
        ev_t e;
        e.t = t;
        e.k = k;
        q.push_back(e);
    endfunction

    task automatic model_step(input int t, input logic s, input logic r, input logic rst);
        logic fs, fr, rs, rr;
        raw_s[t] = s;
        raw_r[t] = r;
        if (rst) begin
            last_rst = t;
            while (q.size() > 0 && q[$].t >= t) void'(q.pop_back());
            if (p_start <= t - 1 && p_start + P >= t)
                push_ev(t, (p_kind == 0) ? K_SR : K_RR);
            deb_s = 1'b1; deb_r = 1'b1;
            fprev_s = 1'b0; fprev_r = 1'b0;
            pend_s_m = 1'b0; pend_r_m = 1'b0;
            next_free = t + 1;
            p_start = -100;
            busy_exp[t] = 1'b0;
            return;
        end
        fs = fprev_s;
        fr = fprev_r;
        fprev_s = 1'b0;
        fprev_r = 1'b0;
        if (flips(0, t, deb_s)) begin deb_s = ~deb_s; fprev_s = ~deb_s; end
        if (flips(1, t, deb_r)) begin deb_r = ~deb_r; fprev_r = ~deb_r; end
        if (t >= next_free) begin
            rs = fs | pend_s_m;
            rr = fr | pend_r_m;
            if (rs && rr) begin
                push_ev(t, K_CF);
                pend_s_m = 1'b0;
                pend_r_m = 1'b0;
            end else if (rs || rr) begin
                push_ev(t, rs ? K_SF : K_RF);
                push_ev(t + P, rs ? K_SR : K_RR);
                p_start = t;
                p_kind = rs ? 0 : 1;
                next_free = t + P + 2;
                pend_s_m = 1'b0;
                pend_r_m = 1'b0;
            end
        end else begin
            pend_s_m = pend_s_m | fs;
            pend_r_m = pend_r_m | fr;
        end
        busy_exp[t] = (t >= p_start && t <= p_start + P);
    endtask

    task automatic step(input logic s, input logic r, input logic rst);
        @(negedge clk);
        set_n_raw = s;
        clr_n_raw = r;
        reset = rst;
        cur_t = edge_cnt + 1;
        model_step(cur_t, s, r, rst);
    endtask

    task automatic hold(input logic s, input logic r, input int n);
        for (int i = 0; i < n; i++) step(s, r, 1'b0);
    endtask

    task automatic match_ev(input int k, input int t);
        int idx;
        idx = -1;
        foreach (q[i]) if (idx < 0 && q[i].t == t && q[i].k == k) idx = i;
        checks++;
        if (idx >= 0) q.delete(idx);
        else begin
            errors++;
            $display("FAIL event %s at edge %0d: observed, none expected", kname(k), t);
        end
    endtask

    always @(negedge clk) begin
        int t;
        t = edge_cnt;
        if (t >= 1 && t < NMAX) begin
            while (q.size() > 0 && q[0].t < t) begin
                checks++;
                errors++;
                $display("FAIL event %s: expected at edge %0d, not seen by edge %0d", kname(q[0].k), q[0].t, t);
                void'(q.pop_front());
            end
            if (prev_s && !Sbar) match_ev(K_SF, t);
            if (!prev_s && Sbar) match_ev(K_SR, t);
            if (prev_r && !Rbar) match_ev(K_RF, t);
            if (!prev_r && Rbar) match_ev(K_RR, t);
            if (conflict) match_ev(K_CF, t);
            checks++;
            if (busy !== busy_exp[t]) begin
                errors++;
                $display("FAIL busy at edge %0d: got %b want %b", t, busy, busy_exp[t]);
            end
            checks++;
            if (Sbar === 1'b0 && Rbar === 1'b0) begin
                errors++;
                $display("FAIL both_low at edge %0d: Sbar=%b Rbar=%b want never both 0", t, Sbar, Rbar);
            end
            prev_s = Sbar;
            prev_r = Rbar;
        end
    end

    initial begin
        int hs, hr, guard;
        logic vs, vr;
        reset = 1'b1;
        set_n_raw = 1'b1;
        clr_n_raw = 1'b1;
        last_rst = 0;
        p_start = -100;
        p_kind = 0;
        model_step(1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        hold(1'b1, 1'b1, 20);

        // Clean set press, then a bouncing clear press
        hold(1'b0, 1'b1, 30);
        hold(1'b1, 1'b1, 20);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
        hold(1'b1, 1'b0, 25);
        hold(1'b1, 1'b1, 20);

        // Simultaneous presses, then a clear that debounces during a set pulse
        hold(1'b0, 1'b0, 20);
        hold(1'b1, 1'b1, 20);
        hold(1'b0, 1'b1, 3);
        hold(1'b0, 1'b0, 20);
        hold(1'b1, 1'b1, 20);

        // Reset on the second cycle of a set pulse
        guard = 0;
        while (p_start != cur_t && guard < 40) begin
            step(1'b0, 1'b1, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 40) begin
            errors++;
            $display("FAIL pulse_before_reset: no set pulse within 40 cycles");
        end
        step(1'b1, 1'b1, 1'b1);
        hold(1'b1, 1'b1, 15);
        hold(1'b0, 1'b1, 20);
        hold(1'b1, 1'b1, 20);

        // Random bouncing presses with rare resets
        hs = 0; hr = 0; vs = 1'b1; vr = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (hs == 0) begin vs = $urandom_range(0, 1); hs = $urandom_range(1, 12); end
            if (hr == 0) begin vr = $urandom_range(0, 1); hr = $urandom_range(1, 12); end
            hs--; hr--;
            step(vs, vr, ($urandom_range(0, 299) == 0));
        end

        hold(1'b1, 1'b1, 40);
        @(negedge clk);
        @(negedge clk);
        while (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL event %s: expected at edge %0d, never seen", kname(q[0].k), q[0].t);
            void'(q.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
